// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch sequencer.
// Reset vector, delay-slot redirect, halt at address zero, fault.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        stall,
  input  logic        branch_req,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_address,
  output logic [31:0] pc_plus8,
  output logic        in_delay_slot,
  output logic        active,
  output logic        fetch_fault,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SLOT   = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pend_q;
  logic [31:0] pend_d;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  logic        live;
  logic        advance;
  logic [31:0] seq_pc;
  logic        seq_halts;
  logic        pend_misaligned;
  logic        pend_halts;

  // Advance qualifier and redirect/halt predicates.
  always_comb begin
    live            = (state_q == ST_RUN) ||
                      (state_q == ST_SLOT);
    advance         = clk_enable & ~stall & live;
    seq_pc          = pc_q + 32'd4;
    seq_halts       = (seq_pc == HALT_ADDRESS);
    pend_misaligned = (pend_q[1:0] != 2'b00);
    pend_halts      = (pend_q == HALT_ADDRESS);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a branch opens one delay slot; halt and
  // fault are terminal until reset.
  always_comb begin
    state_d = state_q;
    if (advance) begin
      unique case (state_q)
        ST_RUN: begin
          if (branch_req) begin
            state_d = ST_SLOT;
          end else if (seq_halts) begin
            state_d = ST_HALTED;
          end
        end
        ST_SLOT: begin
          if (pend_misaligned) begin
            state_d = ST_FAULT;
          end else if (pend_halts) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Datapath next values: PC, pending target, retire count.
  // A branch seen inside a slot is deliberately not captured.
  always_comb begin
    pc_d   = pc_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (advance) begin
      cnt_d = cnt_q + 32'd1;
      if (state_q == ST_RUN) begin
        pc_d = seq_pc;
        if (branch_req) begin
          pend_d = branch_target;
        end
      end else if (!pend_misaligned) begin
        pc_d = pend_q;
      end
    end
  end

  // Datapath registers; reset drops any pending redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_VECTOR;
      pend_q <= 32'd0;
      cnt_q  <= 32'd0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Outputs are taken from registers only.
  always_comb begin
    instr_address = pc_q;
    pc_plus8      = pc_q + 32'd8;
    in_delay_slot = (state_q == ST_SLOT);
    active        = live;
    fetch_fault   = (state_q == ST_FAULT);
    instr_count   = cnt_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench for pc_fetch_unit.
// Behavioural model checked after every edge plus literal pins.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        stall;
  logic        branch_req;
  logic [31:0] branch_target;
  logic [31:0] instr_address;
  logic [31:0] pc_plus8;
  logic        in_delay_slot;
  logic        active;
  logic        fetch_fault;
  logic [31:0] instr_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: fetch address, optional queued redirect, run flags.
  bit [31:0] m_pc;
  bit [31:0] m_tgt;
  bit        m_slot;
  bit        m_active;
  bit        m_fault;
  bit [31:0] m_cnt;

  pc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .stall         (stall),
    .branch_req    (branch_req),
    .branch_target (branch_target),
    .instr_address (instr_address),
    .pc_plus8      (pc_plus8),
    .in_delay_slot (in_delay_slot),
    .active        (active),
    .fetch_fault   (fetch_fault),
    .instr_count   (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = 32'hBFC00000;
    m_tgt    = 32'd0;
    m_slot   = 1'b0;
    m_active = 1'b1;
    m_fault  = 1'b0;
    m_cnt    = 32'd0;
  endtask

  task automatic model_step(input bit en, input bit st,
                            input bit br,
                            input bit [31:0] tgt);
    if (!(en && !st && m_active)) return;
    m_cnt = m_cnt + 1;
    if (m_slot) begin
      m_slot = 1'b0;
      if (m_tgt % 4 != 0) begin
        m_fault  = 1'b1;
        m_active = 1'b0;
      end else begin
        m_pc = m_tgt;
        if (m_pc == 32'h0) m_active = 1'b0;
      end
    end else begin
      m_pc = m_pc + 4;
      if (br) begin
        m_tgt  = tgt;
        m_slot = 1'b1;
      end else if (m_pc == 32'h0) begin
        m_active = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("instr_address", instr_address, m_pc);
    chk("pc_plus8", pc_plus8, m_pc + 32'd8);
    chk("in_delay_slot", {31'd0, in_delay_slot},
        {31'd0, m_slot});
    chk("active", {31'd0, active}, {31'd0, m_active});
    chk("fetch_fault", {31'd0, fetch_fault},
        {31'd0, m_fault});
    chk("instr_count", instr_count, m_cnt);
  endtask

  task automatic cyc(input bit en, input bit st,
                     input bit br, input logic [31:0] tgt);
    clk_enable    = en;
    stall         = st;
    branch_req    = br;
    branch_target = tgt;
    @(posedge clk);
    model_step(en, st, br, tgt);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("rst_pc_immediate", instr_address, 32'hBFC00000);
    chk("rst_fault_clear", {31'd0, fetch_fault}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    clk_enable    = 1'b1;
    stall         = 1'b0;
    branch_req    = 1'b0;
    branch_target = 32'd0;
    reset         = 1'b1;
    model_reset();
    #2;
    check_all();
    chk("reset_pc", instr_address, 32'hBFC00000);
    chk("reset_pc8", pc_plus8, 32'hBFC00008);
    chk("reset_active", {31'd0, active}, 32'd1);
    chk("reset_cnt", instr_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // free run then branch at BFC00008
    cyc(1, 0, 0, 32'd0);
    chk("seq1", instr_address, 32'hBFC00004);
    cyc(1, 0, 0, 32'd0);
    chk("seq2", instr_address, 32'hBFC00008);
    cyc(1, 0, 1, 32'hBFC00020);
    chk("slot_pc", instr_address, 32'hBFC0000C);
    chk("slot_flag", {31'd0, in_delay_slot}, 32'd1);
    chk("slot_pc8", pc_plus8, 32'hBFC00014);
    chk("cnt3", instr_count, 32'd3);
    // branch in slot must be ignored
    cyc(1, 0, 1, 32'hBFC00100);
    chk("target_pc", instr_address, 32'hBFC00020);
    chk("target_noslot", {31'd0, in_delay_slot}, 32'd0);
    repeat (3) cyc(1, 0, 0, 32'd0);
    chk("at_2c", instr_address, 32'hBFC0002C);

    // jr $0
    cyc(1, 0, 1, 32'h0);
    chk("jr0_slot", instr_address, 32'hBFC00030);
    cyc(1, 0, 0, 32'd0);
    chk("halt_pc", instr_address, 32'h0);
    chk("halt_active", {31'd0, active}, 32'd0);
    chk("halt_cnt", instr_count, 32'd9);
    repeat (5) cyc(1, 0, 1, 32'h100);
    chk("halt_frozen", instr_address, 32'h0);
    chk("halt_cnt_frozen", instr_count, 32'd9);
    do_reset();

    // stall lengthens the slot
    cyc(1, 0, 1, 32'hBFC00040);
    repeat (3) cyc(1, 1, 0, 32'd0);
    chk("stall_hold", instr_address, 32'hBFC00004);
    chk("stall_slot", {31'd0, in_delay_slot}, 32'd1);
    cyc(1, 0, 0, 32'd0);
    chk("stall_target", instr_address, 32'hBFC00040);

    // misaligned redirect
    cyc(1, 0, 1, 32'hBFC00022);
    cyc(1, 0, 0, 32'd0);
    chk("fault_flag", {31'd0, fetch_fault}, 32'd1);
    chk("fault_pc", instr_address, 32'hBFC00044);
    chk("fault_cnt", instr_count, 32'd4);
    repeat (2) cyc(1, 0, 0, 32'd0);
    do_reset();

    // clock enable low freezes everything
    repeat (2) cyc(1, 0, 0, 32'd0);
    repeat (4) cyc(0, 0, 1, 32'hBFC00080);
    chk("ce_hold_pc", instr_address, 32'hBFC00008);
    chk("ce_hold_cnt", instr_count, 32'd2);
    cyc(1, 0, 0, 32'd0);
    do_reset();

    // clock enable low inside a slot, then wrap to zero
    cyc(1, 0, 1, 32'hBFC00010);
    repeat (2) cyc(0, 0, 0, 32'd0);
    cyc(1, 0, 0, 32'd0);
    chk("ce_slot_target", instr_address, 32'hBFC00010);
    cyc(1, 0, 1, 32'hFFFFFFFC);
    cyc(1, 0, 0, 32'd0);
    chk("top_pc", instr_address, 32'hFFFFFFFC);
    chk("top_pc8_wrap", pc_plus8, 32'h00000004);
    cyc(1, 0, 0, 32'd0);
    chk("wrap_halt_pc", instr_address, 32'h0);
    chk("wrap_halt_active", {31'd0, active}, 32'd0);
    chk("wrap_cnt", instr_count, 32'd5);
    do_reset();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and fetch-sequencing stage of the Harvard MIPS core. It sits directly upstream of instruction decode and drives `instr_address` to instruction memory. It implements the reset vector, MIPS branch-delay-slot redirection and halt-on-address-zero, and produces the CPU `active` flag. The core's branch/jump resolution logic drives it with one taken/target pair per instruction.

## Interface
- `RESET_VECTOR`, default 32'hBFC00000: PC after reset.
- `HALT_ADDRESS`, default 32'h00000000: arriving PC value that halts the core.

- `clk`  in  1  single system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clk_enable`  in  1  global advance enable; low freezes all state.
- `stall`  in  1  hold current fetch (multicycle op in progress).
- `branch_req`  in  1  instruction at `instr_address` is a taken branch/jump.
- `branch_target`  in  32  redirect address, valid with `branch_req`.
- `instr_address`  out  32  current fetch address.
- `pc_plus8`  out  32  `instr_address + 8`, link value for JAL/JALR/BLTZAL/BGEZAL.
- `in_delay_slot`  out  1  current instruction is a delay-slot instruction.
- `active`  out  1  high while executing; low once halted or faulted.
- `fetch_fault`  out  1  misaligned redirect detected; sticky.
- `instr_count`  out  32  instructions retired since reset.

## Operation
- advance = `clk_enable & ~stall & active`. No advance: every register holds, including the pending target.
- States: RUN, SLOT, HALTED, FAULT.
- RUN, advance, `branch_req`=0: PC <= PC+4. If PC+4 == HALT_ADDRESS, go to HALTED.
- RUN, advance, `branch_req`=1: capture `branch_target` into the pending register, PC <= PC+4, go to SLOT.
- SLOT, advance:
  - pending[1:0] != 0: PC holds, go to FAULT.
  - pending == HALT_ADDRESS: PC <= pending, go to HALTED.
  - otherwise: PC <= pending, go to RUN.
  - `branch_req` in SLOT is ignored; a branch in a delay slot does not redirect.
- HALTED and FAULT are terminal until reset. `active`=0 and PC is frozen in both.
- `in_delay_slot` = (state == SLOT).
- `fetch_fault` = (state == FAULT).
- `instr_count` increments by 1 on every advance. It wraps modulo 2^32.
- All address arithmetic is 32-bit unsigned modulo 2^32. PC 32'hFFFFFFFC + 4 = 32'h00000000, which halts under the default HALT_ADDRESS.

## Timing
- Reset (asynchronous, immediate) values:
  - `instr_address` = RESET_VECTOR; `pc_plus8` = RESET_VECTOR+8.
  - `active`=1, state RUN, `in_delay_slot`=0, `fetch_fault`=0, `instr_count`=0, pending=0.
- Reset asserted mid-operation, including during SLOT, discards the pending target. The first fetch after reset release is RESET_VECTOR.
- All outputs are registered or derived from registers only. No combinational path from any input to any output.
- Redirect latency: a branch sampled on edge N fetches its delay slot after edge N and its target after edge N+1.
- `stall` or `clk_enable`=0 in SLOT lengthens the slot; the target is applied on the first later advance.
- `active` falls on the same edge that loads HALT_ADDRESS into PC. Instruction memory therefore sees address 0 while `active`=0, and the bench checks results on that cycle.
- `branch_req` is sampled only on advancing edges.

## Test plan
- Reset then 3 free advances:
  - `instr_address` sequence BFC00000, BFC00004, BFC00008, BFC0000C.
  - `pc_plus8` tracks +8; `instr_count`=3.
- `branch_req`=1, target BFC00020, applied at BFC00008:
  - fetch sequence BFC0000C with `in_delay_slot`=1, then BFC00020 with `in_delay_slot`=0.
  - `branch_req`=1 with target BFC00100 asserted during the slot is ignored.
- Jump to 0 (jr $0) at BFC0002C:
  - fetches BFC00030 (slot), then 00000000 with `active`=0.
  - PC stays 0 for 5 further cycles; `instr_count` frozen.
- `stall` held 3 cycles while in SLOT (target BFC00040): PC holds at the slot address, then moves to BFC00040 on the first unstalled edge.
- Misaligned target BFC00022: after the slot, `fetch_fault`=1, `active`=0, PC held at the slot address. Asserting `reset` restores BFC00000 and `fetch_fault`=0 without waiting for a clock edge.
- `clk_enable`=0 for 4 edges mid-RUN: no state change. Then reset asserted between clock edges forces `instr_address`=BFC00000 immediately.
